// File: rtl/vadd_seq_ctrl_pkg.sv
// vadd_seq_ctrl_pkg: shared FSM states, SEW codes, opSel constants and beat-count helper
package vadd_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [1:0] SEW_8 = 2'd0, SEW_16 = 2'd1, SEW_32 = 2'd2, SEW_64 = 2'd3;
  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_RSUB = 6'd2;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] beat_count(input logic [CNT_W-1:0] total_bytes);
    return (total_bytes + CNT_W'(7)) >> 3;
  endfunction
endpackage

// File: rtl/vadd_beat_mask.sv
// vadd_beat_mask: write byte-enable; rem = total_bytes mod 8, last = final beat flag, be = enable (low rem bytes on a partial last beat, else all)
module vadd_beat_mask (
  input  logic [2:0] rem,
  input  logic       last,
  output logic [7:0] be
);
  assign be = (last && rem != 3'd0) ? ~(8'hFF << rem) : 8'hFF;
endmodule

// File: rtl/vadd_seq_ctrl.sv
// vadd_seq_ctrl: vector-add sequencer; cmd_* handshake in, rd_* register-file reads, add_* shared adder drive, wr_* result writes, busy/done status
module vadd_seq_ctrl
  import vadd_seq_ctrl_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int SEW_WIDTH      = 2,
  parameter int OPSEL_WIDTH    = 6,
  parameter int ADDR_WIDTH     = 8,
  parameter int VL_WIDTH       = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_vs1,
  input  logic [ADDR_WIDTH-1:0]     cmd_vs2,
  input  logic [ADDR_WIDTH-1:0]     cmd_vd,
  input  logic [VL_WIDTH-1:0]       cmd_vl,
  input  logic [SEW_WIDTH-1:0]      cmd_sew,
  input  logic [OPSEL_WIDTH-1:0]    cmd_opsel,
  output logic                      rd_en,
  output logic [ADDR_WIDTH-1:0]     rd_addr0,
  output logic [ADDR_WIDTH-1:0]     rd_addr1,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data1,
  output logic [REQ_DATA_WIDTH-1:0] add_vec0,
  output logic [REQ_DATA_WIDTH-1:0] add_vec1,
  output logic                      add_carry,
  output logic [SEW_WIDTH-1:0]      add_sew,
  output logic [OPSEL_WIDTH-1:0]    add_opsel,
  input  logic [80:0]               add_result,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [REQ_DATA_WIDTH-1:0] wr_data,
  output logic [7:0]                wr_be,
  output logic                      busy,
  output logic                      done
);
  localparam int TW = VL_WIDTH + 3;
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] vs1_q, vs2_q, vd_q, k1;
  logic [SEW_WIDTH-1:0] sew_q;
  logic [OPSEL_WIDTH-1:0] op_q;
  logic [CNT_W-1:0] beats, beats_q, k;
  logic [2:0] rem_q;
  logic [TW-1:0] total;
  logic v1, last1, last_k, accept, issue;
  logic [7:0] be;
  logic [REQ_DATA_WIDTH-1:0] sum;
  logic [16:0] unused_spare;
  assign total = TW'(cmd_vl) << cmd_sew;
  assign beats = beat_count(CNT_W'(total));
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign accept = cmd_valid && cmd_ready;
  assign issue = state == ISSUE;
  assign last_k = k == beats_q - 1'b1;
  assign rd_en = issue;
  assign rd_addr0 = issue ? vs1_q + ADDR_WIDTH'(k) : '0;
  assign rd_addr1 = issue ? vs2_q + ADDR_WIDTH'(k) : '0;
  assign add_vec0 = v1 ? rd_data0 : '0;
  assign add_vec1 = v1 ? rd_data1 : '0;
  assign add_sew = v1 ? sew_q : '0;
  assign add_opsel = v1 ? op_q : '0;
  assign add_carry = 1'b0;
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign sum[8*i+:8] = add_result[10*i+1+:8];
    assign unused_spare[2*i+:2] = {add_result[10*i+9], add_result[10*i]};
  end
  assign unused_spare[16] = add_result[80];
  vadd_beat_mask u_mask (.rem(rem_q), .last(last1), .be(be));
  always_comb begin
    nxt = state == IDLE  ? (accept ? (beats == '0 ? DONE : ISSUE) : IDLE) :
          state == ISSUE ? (last_k ? DRAIN : ISSUE) :
          state == DRAIN ? (v1 && last1 ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vs1_q <= '0;
      vs2_q <= '0;
      vd_q <= '0;
      sew_q <= '0;
      op_q <= '0;
      beats_q <= '0;
      rem_q <= '0;
      k <= '0;
      k1 <= '0;
      v1 <= 1'b0;
      last1 <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_be <= '0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        vs1_q <= cmd_vs1;
        vs2_q <= cmd_vs2;
        vd_q <= cmd_vd;
        sew_q <= cmd_sew;
        op_q <= cmd_opsel;
        beats_q <= beats;
        rem_q <= total[2:0];
      end
      k <= issue ? k + 1'b1 : '0;
      k1 <= ADDR_WIDTH'(k);
      v1 <= issue;
      last1 <= issue && last_k;
      wr_en <= v1;
      wr_addr <= vd_q + k1;
      wr_data <= sum;
      wr_be <= be;
      done <= state == DONE;
    end
  end
endmodule

// File: tb/tb_vadd_seq_ctrl.sv
// tb_vadd_seq_ctrl: scoreboard bench with register-file and adder models around vadd_seq_ctrl
module tb_vadd_seq_ctrl;
  import vadd_seq_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
  logic [8:0] cmd_vl = '0;
  logic [1:0] cmd_sew = '0;
  logic [5:0] cmd_opsel = '0;
  logic rd_en, add_carry, wr_en, busy, done;
  logic [7:0] rd_addr0, rd_addr1, wr_addr, wr_be;
  logic [63:0] rd_data0, rd_data1, add_vec0, add_vec1, wr_data;
  logic [1:0] add_sew;
  logic [5:0] add_opsel;
  logic [80:0] add_result, junk;
  vadd_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd), .cmd_vl(cmd_vl),
    .cmd_sew(cmd_sew), .cmd_opsel(cmd_opsel), .rd_en(rd_en), .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1), .add_vec0(add_vec0),
    .add_vec1(add_vec1), .add_carry(add_carry), .add_sew(add_sew), .add_opsel(add_opsel),
    .add_result(add_result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .busy(busy), .done(done)
  );
  typedef struct {logic [7:0] a; logic [63:0] d; logic [7:0] be;} wr_t;
  wr_t wq[$];
  logic [15:0] rq[$];
  logic [63:0] mem [256];
  int total = 0, bad = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [1:0] cur_sew = '0;
  logic [5:0] cur_op = '0;
  logic prev_rd = 1'b0;
  wr_t we;
  logic [15:0] re;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] vop(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sew, input logic [5:0] op);
    int w;
    logic [63:0] r, x, y, s, m;
    w = 8 << sew;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    r = '0;
    for (int e = 0; e < 64 / w; e++) begin
      x = (a >> (e * w)) & m;
      y = (b >> (e * w)) & m;
      s = op == OP_SUB ? x - y : op == OP_RSUB ? y - x : x + y;
      r |= (s & m) << (e * w);
    end
    return r;
  endfunction
  always @(posedge clk) junk <= 81'({$urandom, $urandom, $urandom});
  always_comb begin
    logic [63:0] r;
    r = vop(add_vec0, add_vec1, add_sew, add_opsel);
    add_result = junk;
    for (int i = 0; i < 8; i++) add_result[10*i+1+:8] = r[8*i+:8];
  end
  always @(posedge clk) begin
    rd_data0 <= rd_en ? mem[rd_addr0] : {$urandom, $urandom};
    rd_data1 <= rd_en ? mem[rd_addr1] : {$urandom, $urandom};
  end
  always @(negedge clk) begin
    if (rst) prev_rd = 1'b0;
    else begin
      if (rd_en) begin
        rd_cnt++;
        if (rq.size() == 0) chk("rd_unexp", rd_en, 0);
        else begin
          re = rq.pop_front();
          chk("rd_addr0", rd_addr0, re[15:8]);
          chk("rd_addr1", rd_addr1, re[7:0]);
        end
      end
      if (prev_rd) chk("add_sew_op", {add_sew, add_opsel}, {cur_sew, cur_op});
      else begin
        chk("idle_vec0", add_vec0, 0);
        chk("idle_vec1", add_vec1, 0);
        chk("idle_sew_op", {add_sew, add_opsel}, 0);
      end
      chk("add_carry", add_carry, 0);
      if (wr_en) begin
        wr_cnt++;
        if (wq.size() == 0) chk("wr_unexp", wr_en, 0);
        else begin
          we = wq.pop_front();
          chk("wr_addr", wr_addr, we.a);
          chk("wr_data", wr_data, we.d);
          chk("wr_be", wr_be, we.be);
        end
        for (int b = 0; b < 8; b++) if (wr_be[b]) mem[wr_addr][8*b+:8] = wr_data[8*b+:8];
      end
      if (done) done_cnt++;
      prev_rd = rd_en;
    end
  end
  task automatic run_cmd(input logic [7:0] vs1, input logic [7:0] vs2, input logic [7:0] vd,
                         input logic [8:0] vl, input logic [1:0] sew, input logic [5:0] op, input int abort_at);
    int nbytes, beats, rem, n, d0;
    nbytes = int'(vl) << sew;
    beats = (nbytes + 7) / 8;
    rem = nbytes % 8;
    for (int k = 0; k < beats; k++) begin
      if (abort_at == 0 || k < abort_at) rq.push_back({8'(vs1 + k), 8'(vs2 + k)});
      if (abort_at == 0 || k < abort_at - 2)
        wq.push_back('{8'(vd + k), vop(mem[8'(vs1 + k)], mem[8'(vs2 + k)], sew, op),
                       (k == beats - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF});
    end
    rd_cnt = 0;
    wr_cnt = 0;
    d0 = done_cnt;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", cmd_ready, 1);
    cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vd = vd; cmd_vl = vl; cmd_sew = sew; cmd_opsel = op;
    cur_sew = sew; cur_op = op;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      #1 rst = 1'b1;
      cmd_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", cmd_ready, 1);
      chk("busy_after_rst", busy, 0);
      repeat (20) @(negedge clk);
      chk("abort_done", done_cnt - d0, 0);
      chk("abort_wr", wr_cnt, abort_at - 2);
      chk("abort_rd", rd_cnt, abort_at);
    end else begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) chk("busy_t1", busy, 1);
      end while (!done && n < 200);
      chk("done_lat", n, beats == 0 ? 2 : beats + 3);
      chk("rd_cnt", rd_cnt, beats);
      chk("wr_cnt", wr_cnt, beats);
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
  endtask
  initial begin
    logic [7:0] b;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_add_vec0", add_vec0, 0);
    rst = 1'b0;
    run_cmd(8'h10, 8'h20, 8'h30, 9'd16, SEW_8, OP_ADD, 0);
    run_cmd(8'h40, 8'h50, 8'h60, 9'd3, SEW_32, OP_ADD, 0);
    run_cmd(8'h00, 8'h00, 8'h00, 9'd0, SEW_16, OP_ADD, 0);
    mem[8'h70] = 64'd5;
    mem[8'h71] = 64'd7;
    run_cmd(8'h70, 8'h71, 8'h72, 9'd1, SEW_64, OP_SUB, 0);
    chk("sub64", mem[8'h72], 64'hFFFF_FFFF_FFFF_FFFE);
    run_cmd(8'hFF, 8'h80, 8'h90, 9'd8, SEW_16, OP_RSUB, 0);
    run_cmd(8'hA0, 8'hC0, 8'hE0, 9'd64, SEW_8, OP_ADD, 3);
    for (int t = 0; t < 6; t++) begin
      b = 8'($urandom);
      run_cmd(b, 8'(b + 8'h40), 8'(b + 8'h80), 9'($urandom_range(0, 40)), 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 2)), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
